// File: rtl/game_flow_pkg.sv
// rtl/game_flow_pkg.sv - game phase encoding and default phase durations
package game_flow_pkg;

    typedef enum logic [2:0] {
        TITLE       = 3'd0,
        LEVEL_INTRO = 3'd1,
        PLAYING     = 3'd2,
        HIT_FREEZE  = 3'd3,
        LEVEL_CLEAR = 3'd4,
        WIN         = 3'd5,
        GAME_OVER   = 3'd6,
        PAUSED      = 3'd7
    } game_state_t;

    localparam int DEF_NUM_LEVELS        = 3;
    localparam int DEF_LEVEL_WIDTH       = 2;
    localparam int DEF_TIMER_WIDTH       = 7;
    localparam int DEF_INTRO_FRAMES      = 60;
    localparam int DEF_HIT_FREEZE_FRAMES = 20;
    localparam int DEF_CLEAR_FRAMES      = 90;
    localparam int DEF_END_HOLD_FRAMES   = 120;

    // States whose exit is governed by the shared frame timer
    function automatic logic is_timed(input game_state_t s);
        case (s)
            LEVEL_INTRO, HIT_FREEZE, LEVEL_CLEAR, WIN, GAME_OVER: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/game_flow_if.sv
// rtl/game_flow_if.sv - game flow signal bundle; pause_key present when GAME_PAUSE_EN is defined
interface game_flow_if
    import game_flow_pkg::*;
#(
    parameter int LEVEL_WIDTH = DEF_LEVEL_WIDTH
);
    logic                   startOfFrame;
    logic                   start_key;
    logic                   player_hit;
    logic                   player_dead;
    logic                   enemies_cleared;
`ifdef GAME_PAUSE_EN
    logic                   pause_key;
`endif
    game_state_t            game_state;
    logic [LEVEL_WIDTH-1:0] level;
    logic                   freeze;
    logic                   round_resetN;
    logic                   lives_resetN;

    // Game side: supplies frame tick and player/enemy events, consumes phase outputs
    modport master (
        output startOfFrame, start_key, player_hit, player_dead, enemies_cleared,
`ifdef GAME_PAUSE_EN
        output pause_key,
`endif
        input  game_state, level, freeze, round_resetN, lives_resetN
    );

    // Controller side
    modport slave (
        input  startOfFrame, start_key, player_hit, player_dead, enemies_cleared,
`ifdef GAME_PAUSE_EN
        input  pause_key,
`endif
        output game_state, level, freeze, round_resetN, lives_resetN
    );
endinterface

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - load/decrement frame counter shared by all timed game phases
module frame_timer #(
    parameter int TIMER_WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] load_value,
    input  logic                   startOfFrame,
    output logic                   done
);
    logic [TIMER_WIDTH-1:0] count;

    // Load on phase entry wins over a frame tick in the same cycle; count stops at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (startOfFrame && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);
endmodule

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - game phase sequencer; GAME_PAUSE_EN adds pause_key and PAUSED
module game_flow_controller
    import game_flow_pkg::*;
#(
    parameter int NUM_LEVELS        = DEF_NUM_LEVELS,
    parameter int LEVEL_WIDTH       = DEF_LEVEL_WIDTH,
    parameter int TIMER_WIDTH       = DEF_TIMER_WIDTH,
    parameter int INTRO_FRAMES      = DEF_INTRO_FRAMES,
    parameter int HIT_FREEZE_FRAMES = DEF_HIT_FREEZE_FRAMES,
    parameter int CLEAR_FRAMES      = DEF_CLEAR_FRAMES,
    parameter int END_HOLD_FRAMES   = DEF_END_HOLD_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    game_flow_if.slave bus
);
    localparam logic [LEVEL_WIDTH-1:0] LAST_LEVEL = LEVEL_WIDTH'(NUM_LEVELS - 1);

    game_state_t            state, state_next;
    logic [LEVEL_WIDTH-1:0] level, level_next;
    logic                   freeze, freeze_next;
    logic                   round_n, round_n_next;
    logic                   lives_n, lives_n_next;

    logic                   start_key_d, start_edge;
`ifdef GAME_PAUSE_EN
    logic                   pause_key_d, pause_edge;
`endif

    logic                   timer_load;
    logic [TIMER_WIDTH-1:0] timer_value;
    logic                   timer_done;

    frame_timer #(
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_frame_timer (
        .clk          (clk),
        .reset        (reset),
        .load         (timer_load),
        .load_value   (timer_value),
        .startOfFrame (bus.startOfFrame),
        .done         (timer_done)
    );

    // Key history resets high so a key already held during reset produces no edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_key_d <= 1'b1;
`ifdef GAME_PAUSE_EN
            pause_key_d <= 1'b1;
`endif
        end else begin
            start_key_d <= bus.start_key;
`ifdef GAME_PAUSE_EN
            pause_key_d <= bus.pause_key;
`endif
        end
    end

    assign start_edge = bus.start_key & ~start_key_d;
`ifdef GAME_PAUSE_EN
    assign pause_edge = bus.pause_key & ~pause_key_d;
`endif

    // Phase register plus the registered outputs that follow it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= TITLE;
            level   <= '0;
            freeze  <= 1'b1;
            round_n <= 1'b0;
            lives_n <= 1'b0;
        end else begin
            state   <= state_next;
            level   <= level_next;
            freeze  <= freeze_next;
            round_n <= round_n_next;
            lives_n <= lives_n_next;
        end
    end

    // Phase transitions; in PLAYING death beats clear, clear beats hit
    always_comb begin
        state_next = state;
        level_next = level;
        case (state)
            TITLE: begin
                if (start_edge) begin
                    state_next = LEVEL_INTRO;
                    level_next = '0;
                end
            end
            LEVEL_INTRO: begin
                if (timer_done) state_next = PLAYING;
            end
            PLAYING: begin
                if (bus.player_dead)          state_next = GAME_OVER;
                else if (bus.enemies_cleared) state_next = LEVEL_CLEAR;
                else if (bus.player_hit)      state_next = HIT_FREEZE;
`ifdef GAME_PAUSE_EN
                else if (pause_edge)          state_next = PAUSED;
`endif
            end
            HIT_FREEZE: begin
                if (bus.player_dead)   state_next = GAME_OVER;
                else if (timer_done)   state_next = PLAYING;
            end
            LEVEL_CLEAR: begin
                if (timer_done) begin
                    if (level == LAST_LEVEL) begin
                        state_next = WIN;
                    end else begin
                        state_next = LEVEL_INTRO;
                        level_next = level + 1'b1;
                    end
                end
            end
            WIN, GAME_OVER: begin
                if (timer_done && start_edge) state_next = TITLE;
            end
`ifdef GAME_PAUSE_EN
            PAUSED: begin
                if (bus.player_dead)  state_next = GAME_OVER;
                else if (pause_edge)  state_next = PLAYING;
            end
`endif
            default: state_next = TITLE;
        endcase
    end

    // Next values of the registered outputs and the timer load for the phase being entered
    always_comb begin
        freeze_next  = (state_next != PLAYING);
        lives_n_next = ~((state == TITLE) && (state_next == LEVEL_INTRO));
        round_n_next = ~((state_next == LEVEL_INTRO) && (state != LEVEL_INTRO));
        timer_load   = (state_next != state) && is_timed(state_next);
        case (state_next)
            LEVEL_INTRO:    timer_value = TIMER_WIDTH'(INTRO_FRAMES);
            HIT_FREEZE:     timer_value = TIMER_WIDTH'(HIT_FREEZE_FRAMES);
            LEVEL_CLEAR:    timer_value = TIMER_WIDTH'(CLEAR_FRAMES);
            WIN, GAME_OVER: timer_value = TIMER_WIDTH'(END_HOLD_FRAMES);
            default:        timer_value = '0;
        endcase
    end

    assign bus.game_state   = state;
    assign bus.level        = level;
    assign bus.freeze       = freeze;
    assign bus.round_resetN = round_n;
    assign bus.lives_resetN = lives_n;
endmodule

// File: tb/tb_game_flow_controller.sv
// tb/tb_game_flow_controller.sv - randomized scoreboard bench for game_flow_controller
module tb_game_flow_controller;
    import game_flow_pkg::*;

    localparam int INF = 1 << 30;

    typedef struct {
        logic [2:0] st;
        int         lvl;
        logic       frz;
        logic       rn;
        logic       ln;
        int         cyc;
        int         at;
        int         fmin;
        int         fmax;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    game_flow_if #(.LEVEL_WIDTH(2)) bus ();

    game_flow_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    int   cyc_since_evt = 0;
    int   fr_since_state = 0;

    task automatic push(input logic [2:0] st, input int lvl, input logic f, input logic r,
                        input logic l, input int cyc, input int at, input int fmin, input int fmax);
        exp_t e;
        e.st = st; e.lvl = lvl; e.frz = f; e.rn = r; e.ln = l;
        e.cyc = cyc; e.at = at; e.fmin = fmin; e.fmax = fmax;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] st);
        int n = 0;
        while (bus.game_state !== st && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (bus.game_state !== st) begin
            checks++;
            errors++;
            $display("FAIL wait_state: state=%0d after %0d cycles, required %0d", bus.game_state, n, st);
        end
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        @(posedge clk);
        while (fr_since_state < n && k < 4000) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (fr_since_state < n) begin
            checks++;
            errors++;
            $display("FAIL wait_frames: frames=%0d, required %0d", fr_since_state, n);
        end
    endtask

    task automatic press_start();
        step();
        bus.start_key = 1'b1;
        repeat (2) step();
        bus.start_key = 1'b0;
    endtask

    task automatic start_game();
        step();
        push(LEVEL_INTRO, 0, 1, 0, 0, -1, cycle + 1, 0, INF);
        push(LEVEL_INTRO, 0, 1, 1, 1, 1, -1, 0, INF);
        push(PLAYING, 0, 0, 1, 1, -1, -1, 60, 60);
        bus.start_key = 1'b1;
        repeat (2) step();
        bus.start_key = 1'b0;
        wait_state(PLAYING);
    endtask

    task automatic end_phase(input logic [2:0] end_st, input int lvl, input bit early);
        wait_state(end_st);
        if (early) begin
            wait_frames(50);
            press_start();
        end
        wait_frames(120 + $urandom_range(1, 4));
        push(TITLE, lvl, 1, 1, 1, -1, -1, 120, INF);
        press_start();
        wait_state(TITLE);
    endtask

    task automatic kill_player(input int lvl);
        push(GAME_OVER, lvl, 1, 1, 1, -1, cycle + 1, 0, INF);
        bus.player_dead = 1'b1;
        repeat (3) step();
        bus.player_dead = 1'b0;
    endtask

    task automatic play_game(input bit allow_death, input bit force_early);
        int lvl = 0;
        bit over = 0;
        start_game();
        while (!over) begin
            for (int h = 0; h < $urandom_range(0, 2) && !over; h++) begin
                repeat ($urandom_range(1, 20)) step();
                push(HIT_FREEZE, lvl, 1, 1, 1, -1, cycle + 1, 0, INF);
                bus.player_hit = 1'b1;
                step();
                bus.player_hit = 1'b0;
                if (allow_death && $urandom_range(0, 3) == 0) begin
                    wait_state(HIT_FREEZE);
                    repeat ($urandom_range(1, 10)) step();
                    kill_player(lvl);
                    end_phase(GAME_OVER, lvl, force_early | 1'($urandom_range(0, 1)));
                    over = 1;
                end else begin
                    push(PLAYING, lvl, 0, 1, 1, -1, -1, 20, 20);
                    wait_state(PLAYING);
                end
            end
            if (!over) begin
                repeat ($urandom_range(1, 20)) step();
                if (allow_death && $urandom_range(0, 5) == 0) begin
                    kill_player(lvl);
                    end_phase(GAME_OVER, lvl, force_early | 1'($urandom_range(0, 1)));
                    over = 1;
                end else begin
                    push(LEVEL_CLEAR, lvl, 1, 1, 1, -1, cycle + 1, 0, INF);
                    if (lvl == 2) begin
                        push(WIN, lvl, 1, 1, 1, -1, -1, 90, 90);
                    end else begin
                        push(LEVEL_INTRO, lvl + 1, 1, 0, 1, -1, -1, 90, 90);
                        push(LEVEL_INTRO, lvl + 1, 1, 1, 1, 1, -1, 0, INF);
                        push(PLAYING, lvl + 1, 0, 1, 1, -1, -1, 60, 60);
                    end
                    bus.enemies_cleared = 1'b1;
                    bus.player_hit = 1'($urandom_range(0, 1));
                    step();
                    bus.enemies_cleared = 1'b0;
                    bus.player_hit = 1'b0;
                    if (lvl == 2) begin
                        end_phase(WIN, lvl, force_early | 1'($urandom_range(0, 1)));
                        over = 1;
                    end else begin
                        lvl++;
                        wait_state(PLAYING);
                    end
                end
            end
        end
    endtask

    // Frame tick: one-cycle pulse every third clock
    initial begin
        bus.startOfFrame = 1'b0;
        forever begin
            repeat (2) @(posedge clk);
            #1 bus.startOfFrame = 1'b1;
            @(posedge clk);
            #1 bus.startOfFrame = 1'b0;
        end
    end

    // Monitor: every change of the output tuple is an event checked against the queue
    initial begin
        logic [2:0] p_st, c_st;
        int         p_lvl, c_lvl;
        logic       p_f, p_r, p_l, c_f, c_r, c_l;
        bit         have_prev = 0;
        exp_t       e;
        forever begin
            @(posedge clk);
            cycle++;
            cyc_since_evt++;
            if (bus.startOfFrame === 1'b1) fr_since_state++;
            @(negedge clk);
            c_st = bus.game_state; c_lvl = int'(bus.level);
            c_f = bus.freeze; c_r = bus.round_resetN; c_l = bus.lives_resetN;
            if (!have_prev || c_st !== p_st || c_lvl != p_lvl || c_f !== p_f || c_r !== p_r || c_l !== p_l) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got st=%0d lvl=%0d frz=%0b rn=%0b ln=%0b at=%0d, required no change",
                             c_st, c_lvl, c_f, c_r, c_l, cycle);
                end else begin
                    e = exp_q.pop_front();
                    if (c_st !== e.st || c_lvl != e.lvl || c_f !== e.frz || c_r !== e.rn || c_l !== e.ln ||
                        (e.cyc >= 0 && e.cyc != cyc_since_evt) || (e.at >= 0 && e.at != cycle) ||
                        fr_since_state < e.fmin || fr_since_state > e.fmax) begin
                        errors++;
                        $display("FAIL event: got st=%0d lvl=%0d frz=%0b rn=%0b ln=%0b cyc=%0d at=%0d frames=%0d, required st=%0d lvl=%0d frz=%0b rn=%0b ln=%0b cyc=%0d at=%0d frames=%0d..%0d",
                                 c_st, c_lvl, c_f, c_r, c_l, cyc_since_evt, cycle, fr_since_state,
                                 e.st, e.lvl, e.frz, e.rn, e.ln, e.cyc, e.at, e.fmin, e.fmax);
                    end
                end
                if (!have_prev || c_st !== p_st) fr_since_state = 0;
                cyc_since_evt = 0;
                p_st = c_st; p_lvl = c_lvl; p_f = c_f; p_r = c_r; p_l = c_l;
                have_prev = 1;
            end
        end
    end

    // Stimulus
    initial begin
        bus.start_key       = 1'b0;
        bus.player_hit      = 1'b0;
        bus.player_dead     = 1'b0;
        bus.enemies_cleared = 1'b0;
`ifdef GAME_PAUSE_EN
        bus.pause_key       = 1'b0;
`endif
        reset = 1'b1;
        push(TITLE, 0, 1, 0, 0, -1, -1, 0, INF);
        push(TITLE, 0, 1, 1, 1, -1, -1, 0, INF);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) step();

        play_game(0, 1);

        step();
        push(TITLE, 0, 1, 0, 0, -1, -1, 0, INF);
        push(TITLE, 0, 1, 1, 1, -1, -1, 0, INF);
        reset = 1'b1;
        bus.start_key = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (30) step();
        bus.start_key = 1'b0;
        repeat (3) step();

        for (int g = 0; g < 5; g++) play_game(1, 0);

`ifdef GAME_PAUSE_EN
        start_game();
        for (int p = 0; p < 2; p++) begin
            push(PAUSED, 0, 1, 1, 1, -1, cycle + 1, 0, INF);
            bus.pause_key = 1'b1;
            step();
            bus.pause_key = 1'b0;
            repeat (5) step();
            if (p == 0) begin
                push(PLAYING, 0, 0, 1, 1, -1, cycle + 1, 0, INF);
                bus.pause_key = 1'b1;
                step();
                bus.pause_key = 1'b0;
                repeat (5) step();
            end
        end
        kill_player(0);
        end_phase(GAME_OVER, 0, 0);
`endif

        repeat (10) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Run-time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: time=%0t, required finish before 1000000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
